// File: rtl/lcd_write_engine.sv
// rtl/lcd_write_engine.sv - HD44780-style LCD bus write sequencer.
// Drives RS/data setup, a registered E pulse, hold, and the controller execution wait.
module lcd_write_engine #(
  parameter int T_SETUP     = 4,
  parameter int T_EN        = 25,
  parameter int T_HOLD      = 4,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000,
  parameter int CNT_W       = 17
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req,
  input  logic       isData,
  input  logic [7:0] byteIn,
  output logic       ready,
  output logic [7:0] dOut,
  output logic [2:0] ctrl,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EN_HIGH,
    HOLD,
    EXEC_WAIT
  } state_t;

  state_t           state, nextState;
  logic [CNT_W-1:0] cnt, nextCnt;
  logic [7:0]       byteReg;
  logic             rsReg;
  logic             eReg;
  logic             doneReg;
  logic             accept;
  logic             longExec;

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  assign longExec = !rsReg && (byteReg == 8'h01 || byteReg == 8'h02 || byteReg == 8'h03);

  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept    = 1'b1;
          nextState = SETUP;
          nextCnt   = CNT_W'(T_SETUP - 1);
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          nextState = EN_HIGH;
          nextCnt   = CNT_W'(T_EN - 1);
        end else begin
          nextCnt = cnt - 1'b1;
        end
      end
      EN_HIGH: begin
        if (cnt == '0) begin
          nextState = HOLD;
          nextCnt   = CNT_W'(T_HOLD - 1);
        end else begin
          nextCnt = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          nextState = EXEC_WAIT;
          nextCnt   = longExec ? CNT_W'(T_EXEC_LONG - 1) : CNT_W'(T_EXEC - 1);
        end else begin
          nextCnt = cnt - 1'b1;
        end
      end
      EXEC_WAIT: begin
        if (cnt == '0) begin
          nextState = IDLE;
        end else begin
          nextCnt = cnt - 1'b1;
        end
      end
      default: begin
        nextState = IDLE;
        nextCnt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      byteReg <= 8'h00;
      rsReg   <= 1'b0;
      eReg    <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      state   <= nextState;
      cnt     <= nextCnt;
      // E and done are registered so the LCD never sees a decode glitch.
      eReg    <= (nextState == EN_HIGH);
      doneReg <= (state == EXEC_WAIT) && (nextState == IDLE);
      if (accept) begin
        byteReg <= byteIn;
        rsReg   <= isData;
      end
    end
  end

  assign ready = (state == IDLE);
  assign dOut  = byteReg;
  assign ctrl  = {rsReg, 1'b0, eReg};
  assign done  = doneReg;

endmodule
